// File: rtl/prescaled_timer.sv
// Prescaled up/down timer with IDLE/RUN/HALT control, optional auto-reload,
// registered terminal pulse and a saturating completed-period counter.
module prescaled_timer #(
  parameter int CNT_WIDTH      = 8,
  parameter int PRE_WIDTH      = 4,
  parameter int LOOP_CNT_WIDTH = 8
) (
  input  logic                      clkIn,
  input  logic                      rstIn,
  input  logic                      startIn,
  input  logic                      stopIn,
  input  logic [CNT_WIDTH-1:0]      limitIn,
  input  logic [PRE_WIDTH-1:0]      prescaleIn,
  input  logic                      cntDownIn,
  input  logic                      loopIn,
  output logic                      busyOut,
  output logic                      cntDoneOut,
  output logic [CNT_WIDTH-1:0]      cntValOut,
  output logic [LOOP_CNT_WIDTH-1:0] loopCntOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]           state;
  logic [PRE_WIDTH-1:0] prescaler;
  logic [CNT_WIDTH-1:0] limit_l;
  logic [PRE_WIDTH-1:0] prescale_l;
  logic                 down_l;
  logic                 loop_l;

  logic tick;
  logic terminal;

  function automatic logic [LOOP_CNT_WIDTH-1:0] sat_inc(input logic [LOOP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + LOOP_CNT_WIDTH'(1);
  endfunction

  assign tick     = (state == RUN) && (prescaler == prescale_l);
  assign terminal = down_l ? (cntValOut == '0) : (cntValOut == limit_l);

  // Configuration is captured only on an accepted start; it is not reset.
  always_ff @(posedge clkIn) begin
    if (startIn && !stopIn) begin
      limit_l    <= limitIn;
      prescale_l <= prescaleIn;
      down_l     <= cntDownIn;
      loop_l     <= loopIn;
    end
  end

  // Control and output registers; stop takes priority over start.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state      <= IDLE;
      prescaler  <= '0;
      cntValOut  <= '0;
      loopCntOut <= '0;
      cntDoneOut <= 1'b0;
      busyOut    <= 1'b0;
    end else if (stopIn) begin
      state      <= IDLE;
      prescaler  <= '0;
      cntValOut  <= '0;
      loopCntOut <= '0;
      cntDoneOut <= 1'b0;
      busyOut    <= 1'b0;
    end else if (startIn) begin
      state      <= RUN;
      prescaler  <= '0;
      cntValOut  <= cntDownIn ? limitIn : '0;
      loopCntOut <= '0;
      cntDoneOut <= 1'b0;
      busyOut    <= 1'b1;
    end else if (state == RUN) begin
      cntDoneOut <= 1'b0;
      if (!tick) begin
        prescaler <= prescaler + PRE_WIDTH'(1);
      end else begin
        prescaler <= '0;
        if (!terminal) begin
          cntValOut <= down_l ? cntValOut - CNT_WIDTH'(1) : cntValOut + CNT_WIDTH'(1);
        end else begin
          cntDoneOut <= 1'b1;
          loopCntOut <= sat_inc(loopCntOut);
          if (loop_l) begin
            cntValOut <= down_l ? limit_l : '0;
          end else begin
            state   <= HALT;
            busyOut <= 1'b0;
          end
        end
      end
    end else begin
      cntDoneOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaled_timer.sv
// Directed bench for prescaled_timer: each scenario compares the packed
// output vector {busy, done, count, loops} against hand-derived values.
module tb_prescaled_timer;

  logic       clkIn = 1'b0;
  logic       rstIn = 1'b1;
  logic       startIn = 1'b0;
  logic       stopIn = 1'b0;
  logic [7:0] limitIn = '0;
  logic [3:0] prescaleIn = '0;
  logic       cntDownIn = 1'b0;
  logic       loopIn = 1'b0;
  logic       busyOut;
  logic       cntDoneOut;
  logic [7:0] cntValOut;
  logic [7:0] loopCntOut;

  int checks = 0;
  int errors = 0;

  prescaled_timer dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .stopIn(stopIn),
    .limitIn(limitIn), .prescaleIn(prescaleIn), .cntDownIn(cntDownIn),
    .loopIn(loopIn), .busyOut(busyOut), .cntDoneOut(cntDoneOut),
    .cntValOut(cntValOut), .loopCntOut(loopCntOut)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [17:0] pack(input logic b, input logic d,
                                       input logic [7:0] c, input logic [7:0] l);
    return {b, d, c, l};
  endfunction

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l, input logic [3:0] p,
                          input logic down, input logic lp);
    limitIn = l; prescaleIn = p; cntDownIn = down; loopIn = lp; startIn = 1'b1;
    step();
    startIn = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    #2;
    got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
    checks++;
    if (got !== 18'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", got, 18'h0);
    end
    rstIn = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      checks++;
      if (got !== 18'h0) begin
        errors++; $display("FAIL idle_after_reset n=%0d got %h exp %h", n, got, 18'h0);
      end
    end
  endtask

  task automatic test_up_loop();
    logic [7:0]  ec [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic        ed [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic [7:0]  el [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
    logic [17:0] got, exp;
    do_start(8'd3, 4'd0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      exp = pack(1'b1, ed[n], ec[n], el[n]);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL up_loop E%0d got %h exp %h", n, got, exp);
      end
    end
  endtask

  task automatic test_down_oneshot();
    logic [7:0]  ec [9] = '{2, 2, 1, 1, 0, 0, 0, 0, 0};
    logic        ed [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic        eb [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0]  el [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [17:0] got, exp;
    do_start(8'd2, 4'd1, 1'b1, 1'b0);
    for (int n = 0; n < 9; n++) begin
      if (n > 0) step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      exp = pack(eb[n], ed[n], ec[n], el[n]);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL down_oneshot E%0d got %h exp %h", n, got, exp);
      end
    end
  endtask

  task automatic test_zero_limit();
    logic [17:0] got, exp;
    do_start(8'd0, 4'd0, 1'b0, 1'b1);
    for (int n = 0; n < 270; n++) begin
      if (n > 0) step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      exp = pack(1'b1, n > 0, 8'd0, (n > 255) ? 8'd255 : 8'(n));
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL zero_limit E%0d got %h exp %h", n, got, exp);
      end
    end
  endtask

  task automatic test_stop();
    logic [17:0] got, exp;
    do_start(8'd5, 4'd2, 1'b0, 1'b1);
    for (int n = 1; n <= 9; n++) step();
    exp = pack(1'b1, 1'b0, 8'd3, 8'd0);
    got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL stop_pre got %h exp %h", got, exp);
    end
    stopIn = 1'b1;
    step();
    stopIn = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      checks++;
      if (got !== 18'h0) begin
        errors++; $display("FAIL stop_idle n=%0d got %h exp %h", n, got, 18'h0);
      end
    end
    do_start(8'd5, 4'd0, 1'b0, 1'b1);
    step();
    startIn = 1'b1; stopIn = 1'b1;
    step();
    startIn = 1'b0; stopIn = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      checks++;
      if (got !== 18'h0) begin
        errors++; $display("FAIL start_stop_same n=%0d got %h exp %h", n, got, 18'h0);
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0]  ec [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
    logic        ed [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [7:0]  el [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    logic [17:0] got, exp;
    do_start(8'd5, 4'd1, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) step();
    exp = pack(1'b1, 1'b0, 8'd2, 8'd0);
    got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL restart_pre got %h exp %h", got, exp);
    end
    do_start(8'd1, 4'd1, 1'b1, 1'b1);
    limitIn = 8'd7; prescaleIn = 4'd0; cntDownIn = 1'b0; loopIn = 1'b0;
    for (int n = 0; n < 9; n++) begin
      if (n > 0) step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      exp = pack(1'b1, ed[n], ec[n], el[n]);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL restart E%0d got %h exp %h", n, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] got, exp;
    do_start(8'd3, 4'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 6; n++) step();
    exp = pack(1'b1, 1'b0, 8'd2, 8'd1);
    got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL areset_pre got %h exp %h", got, exp);
    end
    #2 rstIn = 1'b1;
    #1;
    got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
    checks++;
    if (got !== 18'h0) begin
      errors++; $display("FAIL areset_immediate got %h exp %h", got, 18'h0);
    end
    #1 rstIn = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      got = {busyOut, cntDoneOut, cntValOut, loopCntOut};
      checks++;
      if (got !== 18'h0) begin
        errors++; $display("FAIL areset_idle n=%0d got %h exp %h", n, got, 18'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_loop();
    test_down_oneshot();
    test_zero_limit();
    test_stop();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_timer.md
PRESCALED_TIMER -- requirements
Module: prescaled_timer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: width of count value and limit.
REQ-002 SHALL have parameter PRE_WIDTH, default 4: width of prescale value.
REQ-003 SHALL have parameter LOOP_CNT_WIDTH, default 8: width of completed-period counter.
REQ-004 SHALL have port clkIn  in  1  clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rstIn  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port startIn  in  1  start/restart request, sampled each edge.
REQ-007 SHALL have port stopIn  in  1  abort request, sampled each edge.
REQ-008 SHALL have port limitIn  in  CNT_WIDTH  terminal value L.
REQ-009 SHALL have port prescaleIn  in  PRE_WIDTH  prescale value P; one tick every P+1 clocks.
REQ-010 SHALL have port cntDownIn  in  1  1 = count down L..0, 0 = count up 0..L.
REQ-011 SHALL have port loopIn  in  1  1 = reload on terminal, 0 = one-shot.
REQ-012 SHALL have port busyOut  out  1  high while in RUN.
REQ-013 SHALL have port cntDoneOut  out  1  terminal pulse.
REQ-014 SHALL have port cntValOut  out  CNT_WIDTH  current count.
REQ-015 SHALL have port loopCntOut  out  LOOP_CNT_WIDTH  completed periods since start.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT; all outputs registered.
REQ-017 Any state, stopIn=1: SHALL go to IDLE, cntValOut=0, loopCntOut=0, cntDoneOut=0; stopIn wins over simultaneous startIn.
REQ-018 Any state, startIn=1 and stopIn=0: SHALL enter RUN, latch L, P, cntDownIn, loopIn, and load cntValOut with 0 (up) or L (down), clear loopCntOut and prescaler; restart from RUN/HALT is allowed.
REQ-019 Config inputs SHALL be ignored outside the start edge; changes during RUN have no effect.
REQ-020 RUN: prescaler SHALL increment each clock; when it equals latched P, that edge is a tick and prescaler returns to 0.
REQ-021 Start accepted at edge E0: ticks SHALL occur at edges E0+n*(P+1), n>=1.
REQ-022 Non-terminal tick SHALL apply cntValOut +1 (up) or -1 (down); terminal tick = tick with cntValOut already at L (up) or 0 (down).
REQ-023 Terminal tick SHALL set cntDoneOut=1 for the following cycle and increment loopCntOut, saturating at all-ones.
REQ-024 Terminal tick with loop: SHALL reload 0 (up) or L (down), stay in RUN; period = (L+1)*(P+1) clocks.
REQ-025 Terminal tick one-shot: SHALL go to HALT, cntValOut holding L (up) or 0 (down).
REQ-026 cntDoneOut SHALL be 0 on every cycle not following a terminal tick; back-to-back terminal ticks (L=0, P=0) keep it continuously high.
REQ-027 L=0: every tick SHALL be terminal; cntValOut stays 0.
REQ-028 busyOut SHALL be 1 exactly in RUN; HALT and IDLE hold cntValOut and loopCntOut unchanged until start/stop.

Reset
REQ-029 rstIn=1 SHALL immediately force IDLE, prescaler=0, cntValOut=0, loopCntOut=0, cntDoneOut=0, busyOut=0, regardless of clock, including mid-RUN.
REQ-030 After rstIn deasserts, block SHALL remain IDLE until startIn.

Verification
REQ-031 Up, L=3, P=0, loop, start at E0 -> cntValOut 0,1,2,3,0,...; cntDoneOut high after E4 and E8; loopCntOut 1 then 2; busyOut stays 1.
REQ-032 Down, L=2, P=1, one-shot -> value 2,2,1,1,0,0 over E0..E5; terminal at E6: cntDoneOut one cycle, HALT, busyOut=0, cntValOut 0 held, loopCntOut=1.
REQ-033 Up, L=0, P=0, loop -> cntValOut constant 0, cntDoneOut continuously high from E1, loopCntOut saturates at 255.
REQ-034 Up, L=5, P=2 running; stopIn at cntValOut=3 -> next cycle IDLE, all outputs 0, no done pulse; startIn+stopIn same edge -> IDLE.
REQ-035 Restart mid-RUN with new L=1, down -> cntValOut=1 immediately, loopCntOut=0, prescaler restarts; limitIn changed to 7 mid-run -> period unchanged.
REQ-036 rstIn pulsed between clock edges during RUN -> outputs 0 before the next edge; no further ticks until startIn.
